// File: rtl/lsfr_pkg.sv
// rtl/lsfr_pkg.sv - shared types, seed defaults and step function for the LSFR word arbiter
package lsfr_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WARM = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [WORD_W-1:0] SEED0_DEF = 32'd364;
   localparam logic [WORD_W-1:0] SEED1_DEF = 32'd1;
   localparam logic [WORD_W-1:0] SEED2_DEF = 32'd2;
   localparam logic [WORD_W-1:0] SEED3_DEF = 32'd3;

   // Packed as {z3,z2,z1,z0}; returns the state after one generator step.
   function automatic logic [4*WORD_W-1:0] lsfr_next(input logic [4*WORD_W-1:0] z);
      logic [WORD_W-1:0] n3;
      n3 = z[3*WORD_W-1:2*WORD_W] ^ (z[2*WORD_W-1:WORD_W] << 31) ^ (z[WORD_W-1:0] >> 1);
      return {n3, z[4*WORD_W-1:3*WORD_W], z[3*WORD_W-1:2*WORD_W], z[2*WORD_W-1:WORD_W]};
   endfunction

endpackage

// File: rtl/lsfr_core.sv
// rtl/lsfr_core.sv - four-word shift-register generator with seed load and step enable
module lsfr_core
   import lsfr_pkg::*;
#(
   parameter logic [WORD_W-1:0] SEED0 = SEED0_DEF,
   parameter logic [WORD_W-1:0] SEED1 = SEED1_DEF,
   parameter logic [WORD_W-1:0] SEED2 = SEED2_DEF,
   parameter logic [WORD_W-1:0] SEED3 = SEED3_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  step,
   input  logic                  load,
   input  logic [4*WORD_W-1:0]   seed,
   output logic [WORD_W-1:0]     z0
);

   logic [4*WORD_W-1:0] z;

   // A load wins over a step issued in the same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         z <= {SEED3, SEED2, SEED1, SEED0};
      end else if (load) begin
         z <= seed;
      end else if (step) begin
         z <= lsfr_next(z);
      end
   end

   assign z0 = z[WORD_W-1:0];

endmodule

// File: rtl/lsfr_word_arbiter.sv
// rtl/lsfr_word_arbiter.sv - sequences seed/warm-up and hands generator words to requesters round-robin
module lsfr_word_arbiter
   import lsfr_pkg::*;
#(
   parameter int                NREQ   = 4,
   parameter int                WARMUP = 16,
   parameter logic [WORD_W-1:0] SEED0  = SEED0_DEF,
   parameter logic [WORD_W-1:0] SEED1  = SEED1_DEF,
   parameter logic [WORD_W-1:0] SEED2  = SEED2_DEF,
   parameter logic [WORD_W-1:0] SEED3  = SEED3_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  seed_load,
   input  logic [4*WORD_W-1:0]   seed_data,
   input  logic [NREQ-1:0]       req,
   output logic [NREQ-1:0]       gnt,
   output logic [WORD_W-1:0]     rnd_data,
   output logic                  ready,
   output logic [1:0]            state
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

   state_t            state_q, state_d;
   logic [CW-1:0]     warm_cnt, warm_d;
   logic [PW-1:0]     rr_start, rr_next, gidx;
   logic [NREQ-1:0]   cand, gnt_d;
   logic [WORD_W-1:0] z0;
   logic              found, step, take;
   int                idx;

   lsfr_core #(
      .SEED0 (SEED0),
      .SEED1 (SEED1),
      .SEED2 (SEED2),
      .SEED3 (SEED3)
   ) u_core (
      .clock (clock),
      .reset (reset),
      .step  (step),
      .load  (seed_load),
      .seed  (seed_data),
      .z0    (z0)
   );

   // The current grantee is masked so a requester dropping req never sees a duplicate.
   always_comb begin
      cand  = req & ~gnt;
      found = 1'b0;
      gidx  = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_start) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && cand[idx]) begin
            found = 1'b1;
            gidx  = PW'(idx);
         end
      end
      rr_next = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      warm_d  = warm_cnt;
      step    = 1'b0;
      take    = 1'b0;
      gnt_d   = '0;
      case (state_q)
         ST_IDLE: begin
            warm_d  = '0;
            state_d = (WARMUP > 0) ? ST_WARM : ST_RUN;
         end
         ST_WARM: begin
            step = 1'b1;
            if (warm_cnt == CW'(WARMUP - 1)) state_d = ST_RUN;
            else                             warm_d  = warm_cnt + 1'b1;
         end
         ST_RUN: begin
            if (found) begin
               take  = 1'b1;
               step  = 1'b1;
               gnt_d = NREQ'(1) << gidx;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (seed_load) begin
         state_d = ST_IDLE;
         warm_d  = '0;
         step    = 1'b0;
         take    = 1'b0;
         gnt_d   = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= (WARMUP > 0) ? ST_WARM : ST_IDLE;
         warm_cnt <= '0;
         rr_start <= '0;
         gnt      <= '0;
         rnd_data <= '0;
      end else begin
         state_q  <= state_d;
         warm_cnt <= warm_d;
         gnt      <= gnt_d;
         if (take) begin
            rnd_data <= z0;
            rr_start <= rr_next;
         end
      end
   end

   assign ready = (state_q == ST_RUN);
   assign state = state_q;

endmodule

// File: tb/tb_lsfr_word_arbiter.sv
// tb/tb_lsfr_word_arbiter.sv - randomized and directed checks of lsfr_word_arbiter against a word-level model
module tb_lsfr_word_arbiter;

   localparam int NREQ = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         seed_load = 1'b0;
   logic         seed_load_w = 1'b0;
   logic [127:0] seed_data = '0;
   logic [3:0]   req = '0;
   logic [3:0]   req_w = '0;
   logic [3:0]   gnt, gnt_w;
   logic [31:0]  rnd_data, rnd_w;
   logic         ready, ready_w;
   logic [1:0]   state, state_w;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mz [4];
   int          m_state;
   int          m_last;
   logic [3:0]  m_gnt;
   logic [31:0] m_rnd;

   logic [31:0] exp_seq [5] = '{32'd364, 32'd1, 32'd2, 32'd3, 32'h800000B4};
   logic [3:0]  exp_rot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   always #5 clock = ~clock;

   lsfr_word_arbiter #(.NREQ(NREQ), .WARMUP(0)) dut (
      .clock     (clock),
      .reset     (reset),
      .seed_load (seed_load),
      .seed_data (seed_data),
      .req       (req),
      .gnt       (gnt),
      .rnd_data  (rnd_data),
      .ready     (ready),
      .state     (state)
   );

   lsfr_word_arbiter #(.NREQ(NREQ), .WARMUP(16)) dut_w (
      .clock     (clock),
      .reset     (reset),
      .seed_load (seed_load_w),
      .seed_data (seed_data),
      .req       (req_w),
      .gnt       (gnt_w),
      .rnd_data  (rnd_w),
      .ready     (ready_w),
      .state     (state_w)
   );

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] z0_after(input int n);
      logic [31:0] a, b, c, d, t;
      a = 32'd364; b = 32'd1; c = 32'd2; d = 32'd3;
      repeat (n) begin
         t = c ^ (b << 31) ^ (a >> 1);
         a = b; b = c; c = d; d = t;
      end
      return a;
   endfunction

   task automatic model_reset();
      mz[0] = 32'd364; mz[1] = 32'd1; mz[2] = 32'd2; mz[3] = 32'd3;
      m_state = 0;
      m_last  = -1;
      m_gnt   = '0;
      m_rnd   = '0;
   endtask

   task automatic model_step();
      logic [31:0] n;
      n = mz[2] ^ (mz[1] << 31) ^ (mz[0] >> 1);
      mz[0] = mz[1]; mz[1] = mz[2]; mz[2] = mz[3]; mz[3] = n;
   endtask

   // Word-level behaviour of the WARMUP=0 instance for one clock edge.
   task automatic model_edge();
      int pick;
      int start;
      int i;
      pick = -1;
      if (seed_load) begin
         mz[0] = seed_data[31:0];  mz[1] = seed_data[63:32];
         mz[2] = seed_data[95:64]; mz[3] = seed_data[127:96];
         m_state = 0;
         m_gnt   = '0;
      end else if (m_state == 0) begin
         m_state = 2;
         m_gnt   = '0;
      end else begin
         start = (m_last + 1) % NREQ;
         for (int k = 0; k < NREQ; k++) begin
            i = (start + k) % NREQ;
            if (pick < 0 && req[i] && !m_gnt[i]) pick = i;
         end
         if (pick >= 0) begin
            m_gnt  = 4'(1 << pick);
            m_rnd  = mz[0];
            m_last = pick;
            model_step();
         end else begin
            m_gnt = '0;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
      check_value("gnt", gnt, m_gnt);
      check_value("rnd_data", rnd_data, m_rnd);
      check_value("ready", ready, m_state == 2);
      check_value("state", state, m_state);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_value("rst_gnt", gnt, 0);
      check_value("rst_rnd", rnd_data, 0);
      check_value("rst_ready", ready, 0);
      check_value("rst_state", state, 0);
      check_value("rst_state_w", state_w, 1);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      model_reset();

      begin : warmup_test
         do_reset();
         req_w = 4'b0001;
         for (int e = 1; e <= 17; e++) begin
            tick();
            if (e <= 16) check_value("warm_ready", ready_w, e == 16);
            else begin
               check_value("warm_gnt", gnt_w, 4'b0001);
               check_value("warm_word", rnd_w, z0_after(16));
            end
         end
         req_w = 4'b0000;
      end

      begin : single_req
         int got, last_t;
         got = 0; last_t = -1;
         do_reset();
         req = 4'b0001;
         for (int t = 1; t <= 20 && got < 5; t++) begin
            tick();
            if (gnt != 0) begin
               check_value("t1_word", rnd_data, exp_seq[got]);
               if (last_t >= 0) check_value("t1_spacing", t - last_t, 2);
               last_t = t;
               got++;
            end
         end
         check_value("t1_count", got, 5);
      end

      begin : all_req
         int got;
         got = 0;
         req = 4'b1111;
         do_reset();
         for (int t = 1; t <= 20 && got < 5; t++) begin
            tick();
            if (gnt != 0) begin
               check_value("t2_gnt", gnt, exp_rot[got]);
               check_value("t2_word", rnd_data, exp_seq[got]);
               got++;
            end
         end
         check_value("t2_count", got, 5);
      end

      begin : reset_mid_grant
         bit seen;
         req = 4'b0001;
         do_reset();
         seen = 0;
         for (int t = 0; t < 10 && !seen; t++) begin
            tick();
            if (gnt != 0) seen = 1;
         end
         check_value("t5_first_grant", seen, 1);
         reset = 1'b1;
         #1;
         check_value("t5_async_gnt", gnt, 0);
         check_value("t5_async_rnd", rnd_data, 0);
         check_value("t5_async_ready", ready, 0);
         check_value("t5_async_state", state, 0);
         check_value("t5_async_state_w", state_w, 1);
         @(posedge clock);
         #1;
         reset = 1'b0;
         model_reset();
         seen = 0;
         for (int t = 0; t < 10 && !seen; t++) begin
            tick();
            if (gnt != 0) begin
               seen = 1;
               check_value("t5_word", rnd_data, 32'd364);
            end
         end
         check_value("t5_regrant", seen, 1);
      end

      begin : seed_vs_req
         bit seen;
         req = 4'b0001;
         seed_load = 1'b1;
         seed_data = {32'd3, 32'd2, 32'd1, 32'd364};
         tick();
         check_value("t4_no_gnt", gnt, 0);
         seed_load = 1'b0;
         seen = 0;
         for (int t = 0; t < 10 && !seen; t++) begin
            tick();
            if (gnt != 0) begin
               seen = 1;
               check_value("t4_word", rnd_data, 32'd364);
            end
         end
         check_value("t4_regrant", seen, 1);
      end

      begin : idle_hold
         bit seen;
         req = 4'b0000;
         for (int t = 0; t < 10; t++) begin
            tick();
            check_value("t6_idle_gnt", gnt, 0);
         end
         check_value("t6_hold_rnd", rnd_data, 32'd364);
         req = 4'b0010;
         seen = 0;
         for (int t = 0; t < 10 && !seen; t++) begin
            tick();
            if (gnt != 0) begin
               seen = 1;
               check_value("t6_next", rnd_data, 32'd1);
            end
         end
         check_value("t6_regrant", seen, 1);
      end

      begin : random_phase
         for (int t = 0; t < 400; t++) begin
            req = 4'($urandom);
            seed_load = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) seed_data = '0;
            else seed_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
         end
         seed_load = 1'b0;
         req = 4'b0000;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
